// File: rtl/data_sync_tx_arbiter.sv
// Source-domain round-robin arbiter feeding one bus synchronizer channel.
// Each granted word is held stable while bus_enable rises once (HOLD), drops (GAP), then acks.
module data_sync_tx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic [BUS_WIDTH-1:0]           unsync_bus,
    output logic                           bus_enable
);
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

    state_t               r_state, w_state_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [ID_W-1:0]      r_ptr, w_ptr_next;
    logic [ID_W-1:0]      r_gid, w_gid_next;
    logic [BUS_WIDTH-1:0] r_bus, w_bus_next;
    logic                 r_be, w_be_next;
    logic [NUM_REQ-1:0]   r_ack, w_ack_next;
    logic                 r_busy, w_busy_next;

    logic [BUS_WIDTH-1:0] w_words [NUM_REQ];
    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_found;
    logic [ID_W-1:0]      w_sel;
    logic [ID_W-1:0]      w_cand;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
        assign w_words[gi] = req_data[gi*BUS_WIDTH +: BUS_WIDTH];
    end

    // The requester being acked this cycle still holds req high; mask it out.
    assign w_elig = req & ~r_ack;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ptr_next   = r_ptr;
        w_gid_next   = r_gid;
        w_bus_next   = r_bus;
        w_be_next    = r_be;
        w_ack_next   = '0;
        w_busy_next  = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_HOLD;
                    w_gid_next   = w_sel;
                    w_ptr_next   = w_sel;
                    w_bus_next   = w_words[w_sel];
                    w_be_next    = 1'b1;
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    w_state_next = S_GAP;
                    w_be_next    = 1'b0;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_state_next      = S_IDLE;
                    w_cnt_next        = '0;
                    w_busy_next       = 1'b0;
                    w_ack_next[r_gid] = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_be_next    = 1'b0;
                w_busy_next  = 1'b0;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= ID_W'(NUM_REQ - 1);
            r_gid   <= '0;
            r_bus   <= '0;
            r_be    <= 1'b0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ptr   <= w_ptr_next;
            r_gid   <= w_gid_next;
            r_bus   <= w_bus_next;
            r_be    <= w_be_next;
            r_ack   <= w_ack_next;
            r_busy  <= w_busy_next;
        end
    end

    assign ack        = r_ack;
    assign busy       = r_busy;
    assign grant_id   = r_gid;
    assign unsync_bus = r_bus;
    assign bus_enable = r_be;
endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Directed bench: per-cycle vector table for contention plus hand sequences
// for reset, single transfer, fairness, abort and a slow-destination end-to-end run.
module tb_data_sync_tx_arbiter;
    logic        clk = 1'b0;
    logic        clk_dst = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [7:0]  d0 = '0, d1 = '0;
    logic [1:0]  ack;
    logic        busy;
    logic        gid;
    logic [7:0]  bus;
    logic        be;

    logic [1:0]  req_e = '0;
    logic [15:0] data_e = '0;
    logic [1:0]  ack_e;
    logic        busy_e;
    logic        gid_e;
    logic [7:0]  bus_e;
    logic        be_e;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always #15 clk_dst = ~clk_dst;

    data_sync_tx_arbiter #(.NUM_REQ(2), .BUS_WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(4)) u_dut (
        .CLK(clk), .RST(rst_n), .req(req), .req_data({d1, d0}), .ack(ack),
        .busy(busy), .grant_id(gid), .unsync_bus(bus), .bus_enable(be)
    );

    data_sync_tx_arbiter #(.NUM_REQ(2), .BUS_WIDTH(8), .HOLD_CYCLES(9), .GAP_CYCLES(9)) u_e2e (
        .CLK(clk), .RST(rst_n), .req(req_e), .req_data(data_e), .ack(ack_e),
        .busy(busy_e), .grant_id(gid_e), .unsync_bus(bus_e), .bus_enable(be_e)
    );

    // Destination side: 2-flop enable synchronizer, edge detect, bus capture.
    logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    int         dst_cnt = 0;
    logic [7:0] caps [4];
    always @(posedge clk_dst) begin
        s1 <= be_e;
        s2 <= s1;
        s3 <= s2;
        if (s2 && !s3) begin
            if (dst_cnt < 4) caps[dst_cnt] <= bus_e;
            dst_cnt <= dst_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] e_ack;
        logic       e_be;
        logic [7:0] e_bus;
        logic       e_busy;
        logic       e_gid;
    } vec_t;

    vec_t tbl [21];

    initial begin
        int rises;
        logic prev_be;
        logic got;

        // req, d0, d1, ack, be, bus, busy, gid
        tbl[0]  = '{2'b11, 8'h11, 8'h22, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{2'b11, 8'h11, 8'h22, 2'b00, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 8'h11, 8'h22, 2'b00, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[3]  = '{2'b11, 8'h99, 8'h22, 2'b00, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[4]  = '{2'b11, 8'h99, 8'h22, 2'b00, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[5]  = '{2'b11, 8'h99, 8'h22, 2'b00, 1'b0, 8'h11, 1'b1, 1'b0};
        tbl[6]  = '{2'b11, 8'h99, 8'h22, 2'b00, 1'b0, 8'h11, 1'b1, 1'b0};
        tbl[7]  = '{2'b11, 8'h99, 8'h22, 2'b00, 1'b0, 8'h11, 1'b1, 1'b0};
        tbl[8]  = '{2'b11, 8'h99, 8'h22, 2'b00, 1'b0, 8'h11, 1'b1, 1'b0};
        tbl[9]  = '{2'b11, 8'h99, 8'h22, 2'b01, 1'b0, 8'h11, 1'b0, 1'b0};
        tbl[10] = '{2'b10, 8'h99, 8'h22, 2'b00, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[11] = '{2'b10, 8'h99, 8'h22, 2'b00, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[12] = '{2'b10, 8'h99, 8'h77, 2'b00, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[13] = '{2'b10, 8'h99, 8'h77, 2'b00, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[14] = '{2'b10, 8'h99, 8'h77, 2'b00, 1'b0, 8'h22, 1'b1, 1'b1};
        tbl[15] = '{2'b10, 8'h99, 8'h77, 2'b00, 1'b0, 8'h22, 1'b1, 1'b1};
        tbl[16] = '{2'b10, 8'h99, 8'h77, 2'b00, 1'b0, 8'h22, 1'b1, 1'b1};
        tbl[17] = '{2'b10, 8'h99, 8'h77, 2'b00, 1'b0, 8'h22, 1'b1, 1'b1};
        tbl[18] = '{2'b10, 8'h99, 8'h77, 2'b10, 1'b0, 8'h22, 1'b0, 1'b1};
        tbl[19] = '{2'b00, 8'h99, 8'h77, 2'b00, 1'b0, 8'h22, 1'b0, 1'b1};
        tbl[20] = '{2'b00, 8'h99, 8'h77, 2'b00, 1'b0, 8'h22, 1'b0, 1'b1};

        // Reset held with both requests pending
        req = 2'b11; d0 = 8'h5A; d1 = 8'hC3;
        repeat (3) @(negedge clk);
        chk("rst_be", 32'(be), 32'h0);
        chk("rst_bus", 32'(bus), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gid", 32'(gid), 32'h0);
        req = '0;
        rst_n = 1'b1;

        // Contention table: first grant after reset goes to requester 0
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            $display("vec %0d: req=%b ack=%b be=%b bus=%h busy=%b gid=%b", c, tbl[c].req, ack, be, bus, busy, gid);
            chk($sformatf("tbl%0d_ack", c), 32'(ack), 32'(tbl[c].e_ack));
            chk($sformatf("tbl%0d_be", c), 32'(be), 32'(tbl[c].e_be));
            chk($sformatf("tbl%0d_bus", c), 32'(bus), 32'(tbl[c].e_bus));
            chk($sformatf("tbl%0d_busy", c), 32'(busy), 32'(tbl[c].e_busy));
            chk($sformatf("tbl%0d_gid", c), 32'(gid), 32'(tbl[c].e_gid));
            req = tbl[c].req; d0 = tbl[c].d0; d1 = tbl[c].d1;
        end

        // Single transfer of 0xA5 from requester 0
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                chk($sformatf("single%0d_ack", c), 32'(ack), (c == 9) ? 32'h1 : 32'h0);
                chk($sformatf("single%0d_be", c), 32'(be), (c <= 4) ? 32'h1 : 32'h0);
                chk($sformatf("single%0d_busy", c), 32'(busy), (c <= 8) ? 32'h1 : 32'h0);
                chk($sformatf("single%0d_bus", c), 32'(bus), 32'hA5);
                chk($sformatf("single%0d_gid", c), 32'(gid), 32'h0);
            end
            $display("single cycle %0d: ack=%b be=%b bus=%h", c, ack, be, bus);
            d0  = 8'hA5;
            req = (c < 10) ? 2'b01 : 2'b00;
        end

        // Fairness: both requests held for 8 transfers
        do_reset();
        rises = 0;
        prev_be = 1'b0;
        for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            if (be && !prev_be) begin
                chk($sformatf("fair_gid%0d", rises), 32'(gid), 32'(rises % 2));
                $display("fair grant %0d at cycle %0d to %0d", rises, c, gid);
                rises++;
            end
            prev_be = be;
            req = 2'b11;
        end
        chk("fair_rises", 32'(rises), 32'd8);

        // Abort: reset during HOLD
        do_reset();
        d0 = 8'h3A; d1 = 8'h5A;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            if (c >= 1) chk($sformatf("abort_hold%0d_be", c), 32'(be), 32'h1);
            req = 2'b01;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_be", 32'(be), 32'h0);
        chk("abort_bus", 32'(bus), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ack", 32'(ack), 32'h0);
        $display("abort: be=%b bus=%h busy=%b", be, bus, busy);
        req = '0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_noack", 32'(ack), 32'h0);
        end
        rst_n = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("post%0d_ack", c), 32'(ack), (c == 9) ? 32'h2 : 32'h0);
            if (c >= 1) begin
                chk($sformatf("post%0d_gid", c), 32'(gid), 32'h1);
                chk($sformatf("post%0d_bus", c), 32'(bus), 32'h5A);
            end
            req = (c < 10) ? 2'b10 : 2'b00;
        end
        $display("post-abort transfer: gid=%0d bus=%h", gid, bus);

        // End-to-end through a slow destination synchronizer
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            req_e  = 2'b01;
            data_e = {8'h00, (w == 0) ? 8'h3C : 8'hC3};
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (ack_e[0]) got = 1'b1;
            end
            chk($sformatf("e2e_ack%0d", w), 32'(got), 32'h1);
            req_e = '0;
            data_e = 16'hFFFF;
            repeat (6) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        chk("e2e_pulses", 32'(dst_cnt), 32'd2);
        chk("e2e_word0", 32'(caps[0]), 32'h3C);
        chk("e2e_word1", 32'(caps[1]), 32'hC3);
        $display("e2e: pulses=%0d w0=%h w1=%h", dst_cnt, caps[0], caps[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/data_sync_tx_arbiter.md
Name: data_sync_tx_arbiter

Overview:
- Source-domain controller that shares one data-synchronizer channel (unsync_bus / bus_enable pair) between NUM_REQ requesters.
- Round-robin arbitration between pending requests. Captures the winner's word and drives it stable onto the channel.
- Sequences the enable level through HOLD and GAP windows so the destination-side synchronizer sees exactly one rising edge per word while the bus is stable.
- Sits in the source clock domain, directly in front of the destination's multi-flop bus synchronizer.

Parameters:
- NUM_REQ, 2, number of requesters; 2..8.
- BUS_WIDTH, 8, width of each data word and of unsync_bus.
- HOLD_CYCLES, 4, source cycles bus_enable is held high per transfer; >=1. Must cover the destination synchronizer depth plus one destination clock.
- GAP_CYCLES, 4, source cycles bus_enable is held low after HOLD with data still stable; >=1.

Ports:
- CLK  in  1  source-domain clock.
- RST  in  1  asynchronous reset, active-low.
- req  in  NUM_REQ  level request per requester; held high until the matching ack.
- req_data  in  NUM_REQ*BUS_WIDTH  requester i word at [i*BUS_WIDTH +: BUS_WIDTH]; sampled only at grant.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- busy  out  1  high while state != IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- unsync_bus  out  BUS_WIDTH  registered word to the synchronizer.
- bus_enable  out  1  registered enable level to the synchronizer.

Behaviour:
- Clock and reset: one clock CLK; RST asynchronous, active-low. All state is registered on posedge CLK or negedge RST.
- Reset values: state=IDLE, unsync_bus=0, bus_enable=0, ack=0, busy=0, grant_id=0, counter=0, rr pointer=NUM_REQ-1 (so requester 0 wins first).
- FSM states: IDLE, HOLD, GAP.
- IDLE:
  - Eligible set = req & ~ack. The requester acked this cycle is masked.
  - If the eligible set is non-empty, select the first set bit searching from pointer+1 upward, mod NUM_REQ.
  - At the next edge: grant_id=sel, pointer=sel, unsync_bus=req_data slice sel, bus_enable=1, counter=0, state=HOLD.
  - If no requester is eligible, stay in IDLE and hold all outputs.
- HOLD:
  - bus_enable=1; counter increments each cycle.
  - After HOLD_CYCLES cycles in HOLD: bus_enable=0, counter=0, state=GAP.
- GAP:
  - bus_enable=0; counter increments each cycle.
  - After GAP_CYCLES cycles in GAP: state=IDLE and ack[grant_id]=1 for exactly one cycle.
- unsync_bus:
  - Changes only on the grant edge.
  - Stable from the first HOLD cycle through the ack cycle and beyond, until the next grant.
- Latency:
  - req sampled high in IDLE at cycle 0 gives bus_enable high in cycles 1..HOLD_CYCLES.
  - bus_enable is low for the next GAP_CYCLES cycles.
  - ack arrives at cycle HOLD_CYCLES+GAP_CYCLES+1.
  - Minimum spacing between successive grants is HOLD_CYCLES+GAP_CYCLES+1 cycles.
- req deassertion mid-transfer is ignored: the transfer completes and ack is still issued.
- req_data changes after the grant do not affect unsync_bus.
- Simultaneous requests: the round-robin pointer guarantees no requester waits more than NUM_REQ-1 transfers.
- ack and a new grant: a new grant may be made in the ack cycle for a different requester; the acked requester is masked in that cycle only.
- Reset mid-operation: all outputs return to reset values immediately. No ack is issued for the aborted transfer. The pointer resets to NUM_REQ-1.
- busy is registered, high exactly in HOLD and GAP.
- Counter width: clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). No wrap is possible before the state exit.

Test Plan:
- Reset: hold RST low with req=2'b11 -> bus_enable=0, unsync_bus=0, ack=0, busy=0. After release, the first grant goes to requester 0.
- Single transfer: defaults, req[0]=1, data0=0xA5 at cycle 0 -> unsync_bus=0xA5 from cycle 1, bus_enable=1 for cycles 1-4 and 0 for cycles 5-8, ack[0]=1 only at cycle 9.
- Contention: req=2'b11, data0=0x11, data1=0x22, both held until acked -> grant order 0 then 1. Bus shows 0x11 then 0x22. Second bus_enable rise at cycle 10. ack[1] at cycle 18.
- Fairness: req=2'b11 held permanently -> grants alternate 0,1,0,1 over 8 transfers. bus_enable has exactly 8 rising edges.
- Abort: RST asserted at cycle 2 during HOLD -> bus_enable=0 and unsync_bus=0 immediately, no ack. A fresh req[1] after release completes normally with ack[1].
- End-to-end: instantiate with a 2-stage destination bus synchronizer clocked at 1/3 of the source rate, HOLD_CYCLES=9, GAP_CYCLES=9, send words 0x3C and 0xC3 -> destination sees exactly two pulses, capturing 0x3C then 0xC3.
